// File: rtl/tcdm_bank_arbiter.sv
// ----------------------------------------------------------------------------
// tcdm_bank_arbiter: round-robin share of one TCDM bank port with in-order
// response routing via an owner FIFO.                            Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tcdm_bank_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned BeWidth       = DataWidth / 8,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq*4-1:0]            req_amo_i,
  input  logic [NumReq-1:0]              req_write_i,
  input  logic [NumReq*DataWidth-1:0]    req_wdata_i,
  input  logic [NumReq*BeWidth-1:0]      req_be_i,
  output logic [NumReq-1:0]              resp_valid_o,
  input  logic [NumReq-1:0]              resp_ready_i,
  output logic [DataWidth-1:0]           resp_rdata_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [AddrWidth-1:0]           out_addr_o,
  output logic [3:0]                     out_amo_o,
  output logic                           out_write_o,
  output logic [DataWidth-1:0]           out_wdata_o,
  output logic [BeWidth-1:0]             out_be_o,
  input  logic                           out_rvalid_i,
  output logic                           out_rready_o,
  input  logic [DataWidth-1:0]           out_rdata_i,
  output logic [CntWidth-1:0]            outstanding_o
);

  localparam int unsigned IdxWidth = $clog2(NumReq);
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [AddrWidth-1:0] addr_arr  [NumReq];
  logic [3:0]           amo_arr   [NumReq];
  logic [DataWidth-1:0] wdata_arr [NumReq];
  logic [BeWidth-1:0]   be_arr    [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr_i[g*AddrWidth +: AddrWidth];
    assign amo_arr[g]   = req_amo_i[g*4 +: 4];
    assign wdata_arr[g] = req_wdata_i[g*DataWidth +: DataWidth];
    assign be_arr[g]    = req_be_i[g*BeWidth +: BeWidth];
  end

  logic [IdxWidth-1:0] rr_ptr_q;
  logic                lock_q;
  logic [IdxWidth-1:0] lock_idx_q;
  logic [IdxWidth-1:0] owner_q [MaxOutstanding];
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [CntWidth-1:0] count_q;

  logic [IdxWidth-1:0] sel;
  logic [IdxWidth-1:0] cand;
  logic [IdxWidth-1:0] head;
  logic                found;
  logic                full;
  logic                empty;
  logic                blocked;
  logic                handshake;
  logic                push;
  logic                pop;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CntWidth'(MaxOutstanding));
  assign empty = (count_q == '0);

  // A held lock pins the selection so a stalled request keeps a stable payload.
  always_comb begin
    sel   = rr_ptr_q;
    cand  = '0;
    found = 1'b0;
    if (lock_q) begin
      sel = lock_idx_q;
    end else begin
      for (int unsigned k = 1; k <= NumReq; k++) begin
        cand = IdxWidth'((32'(rr_ptr_q) + k) % NumReq);
        if (!found && req_valid_i[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end
  end

  assign blocked     = full & ~req_write_i[sel];
  assign out_valid_o = rst_ni & req_valid_i[sel] & ~blocked;
  assign handshake   = out_valid_o & out_ready_i;
  assign push        = handshake & ~req_write_i[sel];

  assign out_addr_o  = addr_arr[sel];
  assign out_amo_o   = amo_arr[sel];
  assign out_write_o = req_write_i[sel];
  assign out_wdata_o = wdata_arr[sel];
  assign out_be_o    = be_arr[sel];

  always_comb begin
    req_ready_o      = '0;
    req_ready_o[sel] = handshake;
  end

  assign head         = owner_q[rd_ptr_q];
  assign out_rready_o = rst_ni & ~empty & resp_ready_i[head];
  assign pop          = out_rvalid_i & out_rready_o;
  assign resp_rdata_o = out_rdata_i;

  always_comb begin
    resp_valid_o       = '0;
    resp_valid_o[head] = rst_ni & out_rvalid_i & ~empty;
  end

  assign outstanding_o = count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q   <= IdxWidth'(NumReq - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (handshake) begin
        rr_ptr_q <= sel;
        lock_q   <= 1'b0;
      end else if (out_valid_o && !out_ready_i) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Owner storage needs no reset: entries are only read below the occupancy count.
  always_ff @(posedge clk_i) begin
    if (push) owner_q[wr_ptr_q] <= sel;
  end

`ifndef SYNTHESIS
  rvalid_while_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(out_rvalid_i && empty));
`endif

endmodule

`default_nettype wire

// File: tb/tb_tcdm_bank_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tcdm_bank_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference model of the arbiter.                   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tcdm_bank_arbiter;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXO = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   addr;
  logic [N*4-1:0]    amo;
  logic [N-1:0]      wr;
  logic [N*DW-1:0]   wdata;
  logic [N*BW-1:0]   be;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready;
  logic [DW-1:0]     resp_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [AW-1:0]     out_addr;
  logic [3:0]        out_amo;
  logic              out_write;
  logic [DW-1:0]     out_wdata;
  logic [BW-1:0]     out_be;
  logic              rvalid;
  logic              out_rready;
  logic [DW-1:0]     rdata;
  logic [2:0]        outstanding;

  tcdm_bank_arbiter #(
    .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid), .req_ready_o(req_ready), .req_addr_i(addr),
    .req_amo_i(amo), .req_write_i(wr), .req_wdata_i(wdata), .req_be_i(be),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_addr_o(out_addr),
    .out_amo_o(out_amo), .out_write_o(out_write), .out_wdata_o(out_wdata),
    .out_be_o(out_be), .out_rvalid_i(rvalid), .out_rready_o(out_rready),
    .out_rdata_i(rdata), .outstanding_o(outstanding)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_ptr;
  bit m_lock;
  int m_lock_idx;
  int owners[$];
  int grants[$];
  bit hold;
  bit auto_resp;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input bit w,
                         input logic [3:0] op, input logic [DW-1:0] d, input logic [BW-1:0] b);
    addr[i*AW +: AW]   = a;
    wr[i]              = w;
    amo[i*4 +: 4]      = op;
    wdata[i*DW +: DW]  = d;
    be[i*BW +: BW]     = b;
  endtask

  // One clock cycle: inputs are set by the caller at the falling edge, the
  // model's expected outputs are compared shortly after, and the model state
  // advances at the next falling edge.
  task automatic step();
    int sel;
    bit ov, hs, full, exp_rr, pop_e;
    logic [N-1:0] exp_rdy, exp_rv;
    if (auto_resp) begin
      rvalid = (owners.size() > 0);
      rdata  = $urandom;
    end
    #1;
    sel = -1;
    if (m_lock) sel = m_lock_idx;
    else
      for (int k = 1; k <= N; k++)
        if (sel < 0 && valid[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
    full    = (owners.size() == MAXO);
    ov      = (sel >= 0) && valid[sel] && !(full && !wr[sel]);
    hs      = ov && out_ready;
    exp_rdy = '0;
    if (hs) exp_rdy[sel] = 1'b1;
    exp_rv  = '0;
    exp_rr  = 1'b0;
    if (owners.size() > 0) begin
      exp_rv[owners[0]] = rvalid;
      exp_rr            = resp_ready[owners[0]];
    end
    pop_e = rvalid && exp_rr;
    if (rst_n) begin
      chk("out_valid", out_valid, ov);
      chk("req_ready", req_ready, exp_rdy);
      chk("outstanding", outstanding, owners.size());
      chk("resp_valid", resp_valid, exp_rv);
      chk("out_rready", out_rready, exp_rr);
      chk("resp_rdata", resp_rdata, rdata);
      if (ov) begin
        chk("out_addr", out_addr, addr[sel*AW +: AW]);
        chk("out_amo", out_amo, amo[sel*4 +: 4]);
        chk("out_write", out_write, wr[sel]);
        chk("out_wdata", out_wdata, wdata[sel*DW +: DW]);
        chk("out_be", out_be, be[sel*BW +: BW]);
      end
    end
    @(negedge clk);
    if (!rst_n) begin
      owners.delete();
      m_ptr  = N - 1;
      m_lock = 1'b0;
    end else begin
      if (pop_e) void'(owners.pop_front());
      if (hs) begin
        grants.push_back(sel);
        m_ptr  = sel;
        m_lock = 1'b0;
        if (!wr[sel]) owners.push_back(sel);
        if (!hold) valid[sel] = 1'b0;
      end else if (ov && !out_ready) begin
        m_lock     = 1'b1;
        m_lock_idx = sel;
      end
    end
  endtask

  task automatic drain();
    valid      = '0;
    resp_ready = '1;
    auto_resp  = 1'b1;
    for (int c = 0; c < 2 * MAXO + 2 && owners.size() > 0; c++) step();
    chk("drain_empty", outstanding, 0);
    auto_resp = 1'b0;
    rvalid    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; valid = '0; addr = '0; amo = '0; wr = '0; wdata = '0; be = '0;
    resp_ready = '0; out_ready = 1'b0; rvalid = 1'b0; rdata = '0;
    hold = 1'b0; auto_resp = 1'b0;
    m_ptr = N - 1; m_lock = 1'b0; m_lock_idx = 0;
    for (int i = 0; i < N; i++) set_req(i, 32'hA0 + i, 1'b0, 4'h0, 32'hD0 + i, 4'hF);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_out_rready", out_rready, 0);
    step();

    // Round-robin among three continuous readers, responses one cycle later
    grants.delete();
    valid = 4'b0111; out_ready = 1'b1; resp_ready = '1; hold = 1'b1; auto_resp = 1'b1;
    repeat (6) step();
    hold = 1'b0;
    chk("rr_count", grants.size(), 6);
    for (int i = 0; i < 6; i++) chk("rr_grant", grants[i], i % 3);
    drain();

    // Stall on requester 1; requester 0 arrives mid-stall
    grants.delete();
    out_ready = 1'b0; valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) valid[0] = 1'b1;
      #1 chk("stall_addr", out_addr, 32'hA1);
      step();
    end
    out_ready = 1'b1;
    step(); step();
    chk("stall_count", grants.size(), 2);
    chk("stall_first", grants[0], 1);
    chk("stall_second", grants[1], 0);
    drain();

    // Fill the owner FIFO, then a blocked read and a passing store
    grants.delete();
    valid = 4'b1111; out_ready = 1'b1;
    repeat (4) step();
    chk("fill_count", grants.size(), 4);
    valid[3] = 1'b1;
    #1;
    chk("full_blocked", out_valid, 0);
    chk("full_outstanding", outstanding, 4);
    step();
    valid[1] = 1'b1; wr[1] = 1'b1;
    #1;
    chk("store_ready", req_ready, 4'b0010);
    chk("store_write", out_write, 1);
    step();
    wr[1] = 1'b0;
    #1 chk("read_still_blocked", out_valid, 0);

    // Pop while full: the pending read waits one more cycle
    rvalid = 1'b1; rdata = 32'h1234_5678; resp_ready = '1;
    #1;
    chk("pop_cycle_blocked", out_valid, 0);
    chk("pop_cycle_rready", out_rready, 1);
    step();
    rvalid = 1'b0;
    #1 chk("next_cycle_grant", req_ready, 4'b1000);
    step();
    chk("refilled", outstanding, 4);
    drain();

    // Owner FIFO [2,0] with requester 2 not ready
    valid = 4'b0100; step();
    valid = 4'b0001; step();
    rvalid = 1'b1; rdata = 32'hCAFE_0002; resp_ready = 4'b1011;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("hold_rready", out_rready, 0);
      chk("hold_resp_valid", resp_valid, 4'b0100);
      step();
    end
    resp_ready = '1;
    #1 chk("deliver_2", resp_valid, 4'b0100);
    step();
    rdata = 32'hCAFE_0000;
    #1 chk("deliver_0", resp_valid, 4'b0001);
    step();
    rvalid = 1'b0;
    chk("owners_drained", outstanding, 0);

    // Reset with three reads outstanding and the lock held
    valid = 4'b1110; out_ready = 1'b1;
    repeat (3) step();
    valid = 4'b0001; out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; valid = 4'b1111; out_ready = 1'b1; rvalid = 1'b0;
    #1;
    chk("post_rst_outstanding", outstanding, 0);
    chk("post_rst_resp_valid", resp_valid, 0);
    chk("post_rst_rready", out_rready, 0);
    chk("post_rst_grant", req_ready, 4'b0001);
    step();
    drain();

    // Randomized traffic honouring the hold-until-ready protocol
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!valid[i] && ($urandom % 3 == 0)) begin
          logic [3:0] op;
          case ($urandom % 3)
            0:       op = 4'h0;
            1:       op = 4'hA;
            default: op = 4'hB;
          endcase
          set_req(i, $urandom, ($urandom % 3 == 0), op, $urandom, 4'($urandom));
          valid[i] = 1'b1;
        end
      out_ready  = ($urandom % 4 != 0);
      resp_ready = 4'($urandom);
      rvalid     = (owners.size() > 0) && ($urandom % 2 == 1);
      rdata      = $urandom;
      step();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
